// File: rtl/ir_flag_decode_if.sv
// Bus between the multicycle controller/datapath and the IR/flag decoder.
// The master drives the load strobes and ALU flags; the slave returns the decoded fields.
interface ir_flag_decode_if #(
    parameter int IW   = 16,
    parameter int CNTW = 16
);
    logic            loadir;
    logic [IW-1:0]   instr_in;
    logic            loadf;
    logic            loadff;
    logic            alu_z;
    logic            alu_n;
    logic            alu_v;
    logic            alu_c;
    logic            id_stb;

    logic [IW-1:0]   ir;
    logic [2:0]      tbt;
    logic            i;
    logic            ld;
    logic            lb;
    logic [2:0]      opc;
    logic [2:0]      rd;
    logic [2:0]      rs;
    logic [IW-1:0]   imm;
    logic [IW-1:0]   boff;
    logic            z;
    logic            n;
    logic            v;
    logic            c;
    logic            cond;
    logic [CNTW-1:0] instr_cnt;
    logic [CNTW-1:0] skip_cnt;

    modport master (
        output loadir, instr_in, loadf, loadff, alu_z, alu_n, alu_v, alu_c, id_stb,
        input  ir, tbt, i, ld, lb, opc, rd, rs, imm, boff, z, n, v, c, cond,
               instr_cnt, skip_cnt
    );

    modport slave (
        input  loadir, instr_in, loadf, loadff, alu_z, alu_n, alu_v, alu_c, id_stb,
        output ir, tbt, i, ld, lb, opc, rd, rs, imm, boff, z, n, v, c, cond,
               instr_cnt, skip_cnt
    );
endinterface

// File: rtl/ir_flag_decode.sv
// Instruction register, status flags, field decode and condition check for the multicycle core,
// plus fetched-instruction and skipped-instruction performance counters.
module ir_flag_decode #(
    parameter int IW   = 16,
    parameter int CNTW = 16
) (
    input  logic               clk,
    input  logic               rst,
    ir_flag_decode_if.slave    bus
);
    logic [IW-1:0]   ir_q;
    logic            z_q;
    logic            n_q;
    logic            v_q;
    logic            c_q;
    logic            cond_w;
    logic [CNTW-1:0] instr_cnt_q;
    logic [CNTW-1:0] skip_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ir_q <= '0;
        end else if (bus.loadir) begin
            ir_q <= bus.instr_in;
        end
    end

    // V and C are only written together with Z and N; a lone loadff is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
            c_q <= 1'b0;
        end else if (bus.loadf) begin
            z_q <= bus.alu_z;
            n_q <= bus.alu_n;
            if (bus.loadff) begin
                v_q <= bus.alu_v;
                c_q <= bus.alu_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_cnt_q <= '0;
            skip_cnt_q  <= '0;
        end else begin
            if (bus.loadir) begin
                instr_cnt_q <= instr_cnt_q + 1'b1;
            end
            if (bus.id_stb && !cond_w) begin
                skip_cnt_q <= skip_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cond_w = 1'b0;
        unique case (ir_q[15:14])
            2'b00: cond_w = z_q;
            2'b01: cond_w = ~z_q & ~n_q;
            2'b10: cond_w = n_q ^ v_q;
            2'b11: cond_w = 1'b1;
            default: cond_w = 1'b0;
        endcase
    end

    // The field map is fixed for a 16-bit word; bit 10 is read differently per class.
    assign bus.ir        = ir_q;
    assign bus.tbt       = ir_q[13:11];
    assign bus.i         = ir_q[10];
    assign bus.ld        = ir_q[10];
    assign bus.lb        = ir_q[10];
    assign bus.opc       = ir_q[9:7];
    assign bus.rd        = ir_q[6:4];
    assign bus.rs        = ir_q[3:1];
    assign bus.imm       = {{(IW-7){ir_q[6]}}, ir_q[6:0]};
    assign bus.boff      = {{(IW-10){ir_q[9]}}, ir_q[9:0]};
    assign bus.z         = z_q;
    assign bus.n         = n_q;
    assign bus.v         = v_q;
    assign bus.c         = c_q;
    assign bus.cond      = cond_w;
    assign bus.instr_cnt = instr_cnt_q;
    assign bus.skip_cnt  = skip_cnt_q;
endmodule

// File: tb/tb_ir_flag_decode.sv
// Directed bench for ir_flag_decode: one full-width instance and one with 4-bit counters
// driven by the same stimulus so counter wrap can be observed.
module tb_ir_flag_decode;
    logic        clk = 1'b0;
    logic        rst;
    logic        loadir;
    logic [15:0] instr_in;
    logic        loadf;
    logic        loadff;
    logic        alu_z;
    logic        alu_n;
    logic        alu_v;
    logic        alu_c;
    logic        id_stb;

    int errors = 0;
    int checks = 0;

    ir_flag_decode_if #(.IW(16), .CNTW(16)) bus16 ();
    ir_flag_decode_if #(.IW(16), .CNTW(4))  bus4 ();

    assign bus16.loadir   = loadir;
    assign bus16.instr_in = instr_in;
    assign bus16.loadf    = loadf;
    assign bus16.loadff   = loadff;
    assign bus16.alu_z    = alu_z;
    assign bus16.alu_n    = alu_n;
    assign bus16.alu_v    = alu_v;
    assign bus16.alu_c    = alu_c;
    assign bus16.id_stb   = id_stb;

    assign bus4.loadir    = loadir;
    assign bus4.instr_in  = instr_in;
    assign bus4.loadf     = loadf;
    assign bus4.loadff    = loadff;
    assign bus4.alu_z     = alu_z;
    assign bus4.alu_n     = alu_n;
    assign bus4.alu_v     = alu_v;
    assign bus4.alu_c     = alu_c;
    assign bus4.id_stb    = id_stb;

    ir_flag_decode #(.IW(16), .CNTW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    ir_flag_decode #(.IW(16), .CNTW(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after a rising edge and outputs are sampled there too.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic setFlags(input logic f, input logic ff, input logic [3:0] znvc);
        loadf  = f;
        loadff = ff;
        {alu_z, alu_n, alu_v, alu_c} = znvc;
    endtask

    initial begin
        rst = 1'b0; loadir = 1'b1; instr_in = 16'hFFFF;
        setFlags(1'b1, 1'b1, 4'b1111);
        id_stb = 1'b0;
        #1;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_ir",        32'(bus16.ir),        32'h0);
        checkOutput("rst_cond",      32'(bus16.cond),      32'h0);
        checkOutput("rst_instr_cnt", 32'(bus16.instr_cnt), 32'h0);
        checkOutput("rst_skip_cnt",  32'(bus16.skip_cnt),  32'h0);
        checkOutput("rst_flags",     32'({bus16.z, bus16.n, bus16.v, bus16.c}), 32'h0);
        checkOutput("rst_boff",      32'(bus16.boff),      32'h0);

        rst = 1'b1; instr_in = 16'h4C85;
        setFlags(1'b0, 1'b0, 4'b0000);
        applyStimulus();
        loadir = 1'b0;
        checkOutput("dec_tbt",  32'(bus16.tbt),  32'h1);
        checkOutput("dec_i",    32'(bus16.i),    32'h1);
        checkOutput("dec_opc",  32'(bus16.opc),  32'h1);
        checkOutput("dec_rd",   32'(bus16.rd),   32'h0);
        checkOutput("dec_rs",   32'(bus16.rs),   32'h2);
        checkOutput("dec_imm",  32'(bus16.imm),  32'h0005);
        checkOutput("dec_boff", 32'(bus16.boff), 32'h0085);
        checkOutput("dec_cond_gt", 32'(bus16.cond), 32'h1);
        checkOutput("dec_instr_cnt", 32'(bus16.instr_cnt), 32'h1);

        setFlags(1'b1, 1'b0, 4'b1111);
        applyStimulus();
        checkOutput("flags_zn_only", 32'({bus16.z, bus16.n, bus16.v, bus16.c}), 32'hC);
        checkOutput("cond_gt_fail",  32'(bus16.cond), 32'h0);
        setFlags(1'b1, 1'b1, 4'b0011);
        applyStimulus();
        checkOutput("flags_all", 32'({bus16.z, bus16.n, bus16.v, bus16.c}), 32'h3);
        setFlags(1'b0, 1'b1, 4'b1100);
        applyStimulus();
        checkOutput("flags_ff_ignored", 32'({bus16.z, bus16.n, bus16.v, bus16.c}), 32'h3);

        loadir = 1'b1; instr_in = 16'h8000;
        setFlags(1'b1, 1'b1, 4'b0110);
        applyStimulus();
        loadir = 1'b0;
        setFlags(1'b0, 1'b0, 4'b0000);
        checkOutput("cond_lt_fail", 32'(bus16.cond), 32'h0);
        id_stb = 1'b1;
        applyStimulus();
        id_stb = 1'b0;
        checkOutput("skip_cnt_1", 32'(bus16.skip_cnt), 32'h1);
        setFlags(1'b1, 1'b1, 4'b0100);
        applyStimulus();
        setFlags(1'b0, 1'b0, 4'b0000);
        checkOutput("cond_lt_pass", 32'(bus16.cond), 32'h1);
        id_stb = 1'b1;
        applyStimulus();
        id_stb = 1'b0;
        checkOutput("skip_cnt_hold", 32'(bus16.skip_cnt), 32'h1);

        loadir = 1'b1; instr_in = 16'hE9FF;
        applyStimulus();
        checkOutput("boff_pos", 32'(bus16.boff), 32'h01FF);
        checkOutput("imm_neg",  32'(bus16.imm),  32'hFFFF);
        checkOutput("tbt_101",  32'(bus16.tbt),  32'h5);
        checkOutput("lb_0",     32'(bus16.lb),   32'h0);
        checkOutput("cond_al",  32'(bus16.cond), 32'h1);
        instr_in = 16'hEA00;
        applyStimulus();
        checkOutput("boff_neg", 32'(bus16.boff), 32'hFE00);
        checkOutput("imm_zero", 32'(bus16.imm),  32'h0000);
        checkOutput("instr_cnt_4", 32'(bus16.instr_cnt), 32'h4);

        instr_in = 16'h3800;
        for (int k = 0; k < 13; k++) begin
            applyStimulus();
        end
        loadir = 1'b0;
        checkOutput("instr_cnt_17",  32'(bus16.instr_cnt), 32'h11);
        checkOutput("instr_cnt_wrap", 32'(bus4.instr_cnt), 32'h1);

        loadir = 1'b1; instr_in = 16'h0000;
        setFlags(1'b1, 1'b0, 4'b1000);
        applyStimulus();
        loadir = 1'b0;
        setFlags(1'b0, 1'b0, 4'b0000);
        checkOutput("same_cycle_cond", 32'(bus16.cond), 32'h1);
        checkOutput("same_cycle_cnt4", 32'(bus4.instr_cnt), 32'h2);

        rst = 1'b0; loadir = 1'b1; instr_in = 16'hFFFF; id_stb = 1'b1;
        setFlags(1'b1, 1'b1, 4'b1111);
        applyStimulus();
        checkOutput("rst_wins_ir",    32'(bus16.ir),        32'h0);
        checkOutput("rst_wins_flags", 32'({bus16.z, bus16.n, bus16.v, bus16.c}), 32'h0);
        checkOutput("rst_wins_cnt",   32'(bus16.instr_cnt), 32'h0);
        checkOutput("rst_wins_skip",  32'(bus16.skip_cnt),  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
